// File: rtl/dec_pkg.sv
// Shared types and helpers for the streaming one-hot decoder.
// Holds the skid-buffer state encoding, default parameter values and the decode function.
// No ports; imported by dec_skid_buf and dec_onehot_stream.
package dec_pkg;

  localparam int DEC_IN_W      = 2;
  localparam int DEC_CNT_W     = 8;
  // The decode helper works on a fixed maximum width; callers cast down to OUT_W.
  localparam int DEC_MAX_IN_W  = 6;
  localparam int DEC_MAX_OUT_W = 1 << DEC_MAX_IN_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // word[k] = en & (code == k); an all-zero word when disabled.
  function automatic logic [DEC_MAX_OUT_W-1:0] onehot(input logic [DEC_MAX_IN_W-1:0] code,
                                                      input logic en);
    logic [DEC_MAX_OUT_W-1:0] word;
    word = '0;
    if (en) word[code] = 1'b1;
    return word;
  endfunction

endpackage

// File: rtl/dec_skid_buf.sv
// Generic 2-entry skid buffer: main register M drives the output, S catches one extra word.
// Latency 1 cycle when empty; 1 word/cycle sustained under continuous out_ready.
// Backpressure: in_ready comes straight from the state flops (low only in FULL).
// Ports: clk, rst (async high), in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module dec_skid_buf
  import dec_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  state_t         state_q, state_d;
  logic [W-1:0]   m_q, m_d;
  logic [W-1:0]   s_q, s_d;
  logic           in_fire;
  logic           out_fire;

  // Both handshake qualifiers depend only on state flops, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = m_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          m_d     = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          m_d = in_data;
        end else if (in_fire) begin
          s_d     = in_data;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          m_d     = s_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

endmodule

// File: rtl/dec_onehot_stream.sv
// Streaming binary-to-one-hot decoder behind a 2-entry skid buffer.
// Latency 1 cycle from in_fire to out_valid when empty; full throughput.
// Backpressure: registered in_ready, low only while both skid entries are occupied.
// Ports: clk, rst, in_valid/in_ready/in_code/in_en, out_valid/out_ready/out_onehot,
//        and with DEC_HIT_CNT_EN defined: hit_clr, hit_cnt (saturating per-line hit counters).
// IN_W must not exceed DEC_MAX_IN_W.
module dec_onehot_stream
  import dec_pkg::*;
#(
  parameter  int IN_W  = DEC_IN_W,
  parameter  int CNT_W = DEC_CNT_W,
  localparam int OUT_W = 1 << IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_onehot
`ifdef DEC_HIT_CNT_EN
  ,
  input  logic                   hit_clr,
  output logic [OUT_W*CNT_W-1:0] hit_cnt
`endif
);

  logic [OUT_W-1:0] dec_word;

  assign dec_word = OUT_W'(onehot(DEC_MAX_IN_W'(in_code), in_en));

  dec_skid_buf #(
    .W(OUT_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (dec_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_onehot)
  );

`ifdef DEC_HIT_CNT_EN
  logic             out_fire;
  logic [CNT_W-1:0] cnt_q [OUT_W];
  logic [CNT_W-1:0] cnt_d [OUT_W];

  assign out_fire = out_valid & out_ready;

  // Clear wins over a same-cycle hit; counters stop at all-ones.
  always_comb begin
    for (int k = 0; k < OUT_W; k++) begin
      cnt_d[k] = cnt_q[k];
      if (hit_clr) begin
        cnt_d[k] = '0;
      end else if (out_fire && out_onehot[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < OUT_W; k++) cnt_q[k] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar k = 0; k < OUT_W; k++) begin : g_pack
    assign hit_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
  end
`endif

endmodule

// File: tb/tb_dec_onehot_stream.sv
module tb_dec_onehot_stream;

  localparam int IN_W  = 2;
  localparam int OUT_W = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_code;
  logic             in_en;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_onehot;
`ifdef DEC_HIT_CNT_EN
  logic                   hit_clr;
  logic [OUT_W*CNT_W-1:0] hit_cnt;
  int                     hit_exp [OUT_W];
`endif

  int vectors;
  int miscompares;

  // Reference model: an ordered queue of accepted words, capacity 2.
  logic [OUT_W-1:0] mq[$];
  logic             obs_vld, obs_rdy, exp_vld, exp_rdy, in_fired;
  logic [OUT_W-1:0] obs_word, exp_word;

`ifdef DEC_HIT_CNT_EN
  dec_onehot_stream #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_en(in_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .hit_clr(hit_clr), .hit_cnt(hit_cnt));
`else
  dec_onehot_stream #(.IN_W(IN_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_en(in_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot));
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Samples the DUT at the current negedge, derives what the model expects,
  // advances the model by one clock and moves to the next negedge.
  task automatic tick();
    obs_vld  = out_valid;
    obs_rdy  = in_ready;
    obs_word = out_onehot;
    exp_vld  = (mq.size() != 0);
    exp_rdy  = (mq.size() < 2);
    exp_word = exp_vld ? mq[0] : '0;
`ifdef DEC_HIT_CNT_EN
    if (hit_clr) begin
      for (int k = 0; k < OUT_W; k++) hit_exp[k] = 0;
    end else if (exp_vld && out_ready) begin
      for (int k = 0; k < OUT_W; k++)
        if (exp_word[k] && hit_exp[k] < CMAX) hit_exp[k]++;
    end
`endif
    if (exp_vld && out_ready) void'(mq.pop_front());
    in_fired = in_valid && exp_rdy;
    if (in_fired) mq.push_back(in_en ? OUT_W'(1 << in_code) : '0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_code = '0;
    in_en = 1'b0;
    out_ready = 1'b1;
`ifdef DEC_HIT_CNT_EN
    hit_clr = 1'b0;
    for (int k = 0; k < OUT_W; k++) hit_exp[k] = 0;
`endif
    mq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid got %b expected 0", out_valid);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready got %b expected 1", in_ready);
    end
    vectors++;
    if (out_onehot !== 4'b0000) begin
      miscompares++; $display("FAIL reset_out_onehot got %b expected 0000", out_onehot);
    end
  endtask

  task automatic test_back_to_back();
    logic [OUT_W-1:0] want;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4);
      in_code  = IN_W'(i);
      in_en    = 1'b1;
      tick();
      want = (i >= 1 && i <= 4) ? OUT_W'(1 << (i - 1)) : '0;
      vectors++;
      if (obs_vld !== (i >= 1 && i <= 4)) begin
        miscompares++; $display("FAIL b2b_valid cycle %0d got %b", i, obs_vld);
      end
      vectors++;
      if (obs_rdy !== 1'b1) begin
        miscompares++; $display("FAIL b2b_in_ready cycle %0d got %b expected 1", i, obs_rdy);
      end
      if (i >= 1 && i <= 4) begin
        vectors++;
        if (obs_word !== want) begin
          miscompares++; $display("FAIL b2b_word cycle %0d got %b expected %b", i, obs_word, want);
        end
      end
    end
  endtask

  task automatic test_disable();
    logic [OUT_W-1:0] want [2];
    want[0] = 4'b0000;
    want[1] = 4'b1000;
    out_ready = 1'b1;
    in_valid = 1'b1; in_code = 2'd2; in_en = 1'b0;
    tick();
    in_code = 2'd3; in_en = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs_vld !== 1'b1 || obs_word !== want[i]) begin
        miscompares++;
        $display("FAIL disable_word %0d got vld=%b %b expected vld=1 %b", i, obs_vld, obs_word, want[i]);
      end
      tick();
    end
    vectors++;
    if (obs_vld !== 1'b0) begin
      miscompares++; $display("FAIL disable_drain got vld=%b expected 0", obs_vld);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_en = 1'b1; in_code = 2'd1;
    tick();
    in_code = 2'd2;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs_rdy !== 1'b0 || obs_vld !== 1'b1 || obs_word !== 4'b0010) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d got rdy=%b vld=%b %b expected rdy=0 vld=1 0010",
                 i, obs_rdy, obs_vld, obs_word);
      end
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (obs_word !== 4'b0010 || obs_vld !== 1'b1) begin
      miscompares++; $display("FAIL bp_release1 got vld=%b %b expected vld=1 0010", obs_vld, obs_word);
    end
    tick();
    vectors++;
    if (obs_word !== 4'b0100 || obs_vld !== 1'b1 || obs_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release2 got vld=%b rdy=%b %b expected vld=1 rdy=1 0100", obs_vld, obs_rdy, obs_word);
    end
    tick();
    vectors++;
    if (obs_vld !== 1'b0 || obs_rdy !== 1'b1) begin
      miscompares++; $display("FAIL bp_empty got vld=%b rdy=%b expected 0 1", obs_vld, obs_rdy);
    end
  endtask

  task automatic test_random_stream();
    int accepted, emitted, cyc, bad;
    accepted = 0; emitted = 0; cyc = 0; bad = 0;
    in_valid = 1'b0;
    in_fired = 1'b0;
    while (accepted < 200 && cyc < 3000) begin
      if (!in_valid || in_fired) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_code  = IN_W'($urandom_range(0, 3));
        in_en    = ($urandom_range(0, 7) != 0);
      end
      out_ready = $urandom_range(0, 1);
      tick();
      if (in_fired) accepted++;
      if (obs_vld === 1'b1 && out_ready) emitted++;
      vectors++;
      if (obs_vld !== exp_vld || obs_rdy !== exp_rdy || (exp_vld && obs_word !== exp_word)) begin
        miscompares++; bad++;
        if (bad <= 5)
          $display("FAIL rand_stream cycle %0d got vld=%b rdy=%b %b expected vld=%b rdy=%b %b",
                   cyc, obs_vld, obs_rdy, obs_word, exp_vld, exp_rdy, exp_word);
      end
      cyc++;
    end
    vectors++;
    if (accepted < 200) begin
      miscompares++; $display("FAIL rand_budget accepted %0d words expected 200", accepted);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs_vld === 1'b1) emitted++;
    end
    vectors++;
    if (emitted != accepted) begin
      miscompares++; $display("FAIL rand_count emitted %0d expected %0d", emitted, accepted);
    end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_valid = 1'b1; in_en = 1'b1; in_code = 2'd3;
    tick();
    in_code = 2'd0;
    tick();
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL rstfull_setup in_ready got %b expected 0", in_ready);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_onehot !== 4'b0000 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstfull_immediate got vld=%b %b rdy=%b expected 0 0000 1", out_valid, out_onehot, in_ready);
    end
    mq.delete();
`ifdef DEC_HIT_CNT_EN
    for (int k = 0; k < OUT_W; k++) hit_exp[k] = 0;
`endif
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs_vld !== 1'b0) begin
        miscompares++; $display("FAIL rstfull_after cycle %0d got vld=%b expected 0", i, obs_vld);
      end
    end
  endtask

`ifdef DEC_HIT_CNT_EN
  task automatic test_hit_cnt();
    logic [OUT_W*CNT_W-1:0] want;
    apply_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_en = 1'b1; in_code = 2'd1;
    repeat (5) tick();
    in_valid = 1'b0;
    repeat (2) tick();
    for (int k = 0; k < OUT_W; k++) want[k*CNT_W +: CNT_W] = CNT_W'(hit_exp[k]);
    vectors++;
    if (hit_cnt !== want || hit_cnt !== 8'h0C) begin
      miscompares++; $display("FAIL hit_saturate got %h expected %h", hit_cnt, want);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    hit_clr = 1'b1;
    tick();
    hit_clr = 1'b0;
    vectors++;
    if (obs_vld !== 1'b1 || obs_word !== 4'b0010) begin
      miscompares++; $display("FAIL hit_clr_fire got vld=%b %b expected 1 0010", obs_vld, obs_word);
    end
    vectors++;
    if (hit_cnt !== '0) begin
      miscompares++; $display("FAIL hit_clr got %h expected 00", hit_cnt);
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_code = '0;
    in_en = 1'b0;
    out_ready = 1'b1;
`ifdef DEC_HIT_CNT_EN
    hit_clr = 1'b0;
`endif
    test_reset();
    test_back_to_back();
    test_disable();
    test_backpressure();
    test_random_stream();
    test_reset_full();
`ifdef DEC_HIT_CNT_EN
    test_hit_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
